// File: rtl/map_table_ckpt_pkg.sv
// Shared types and helpers for the rename map table and its checkpoint stack.
package map_table_ckpt_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int DISPATCH_W    = 2;
    localparam int CDB_W         = 2;
    localparam int RETIRE_W      = 2;
    localparam int NUM_CKPT      = 4;
    localparam int PREG_W        = $clog2(NUM_PHYS_REGS);
    localparam int AREG_W        = $clog2(NUM_ARCH_REGS);
    localparam int CKPT_W        = $clog2(NUM_CKPT);
    localparam int WAY_W         = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    typedef struct packed {
        logic [PREG_W-1:0] phys_reg;
        logic              valid;
        logic              ready;
    } tag_t;

    typedef tag_t [NUM_ARCH_REGS-1:0] map_t;

    // ID rename write, IR retire write, branch resolution
    typedef struct packed {
        logic              en;
        logic [AREG_W-1:0] idx;
        tag_t              tag;
    } wr_pkt_t;

    typedef struct packed {
        logic              en;
        logic [AREG_W-1:0] idx;
        tag_t              tag;
    } retire_pkt_t;

    typedef struct packed {
        logic              resolve;
        logic              mispredict;
        logic [CKPT_W-1:0] id;
    } br_pkt_t;

    function automatic tag_t reset_tag(input int i);
        tag_t t;
        t.phys_reg = PREG_W'(i);
        t.valid    = 1'b1;
        t.ready    = 1'b1;
        return t;
    endfunction

    function automatic tag_t wake(input tag_t t, input logic [CDB_W-1:0] en,
                                  input tag_t [CDB_W-1:0] cdb);
        tag_t r;
        r = t;
        for (int c = 0; c < CDB_W; c++)
            if (en[c] && cdb[c].phys_reg == t.phys_reg) r.ready = 1'b1;
        return r;
    endfunction

    // Map lookup for way k, overridden by the youngest older-way write to the same index
    function automatic tag_t fwd(input int k, input logic [AREG_W-1:0] idx, input map_t m,
                                 input wr_pkt_t [DISPATCH_W-1:0] wr);
        tag_t r;
        r = m[idx];
        for (int j = 0; j < DISPATCH_W; j++)
            if (j < k && wr[j].en && wr[j].idx == idx) r = wr[j].tag;
        if (idx == '0) r = reset_tag(0);
        return r;
    endfunction
endpackage

// File: rtl/map_table_ckpt_if.sv
// ID / CDB / IR / branch signals seen by the rename map table.
interface map_table_ckpt_if;
    import map_table_ckpt_pkg::*;

    logic [DISPATCH_W-1:0][AREG_W-1:0] rd_idx_1;
    logic [DISPATCH_W-1:0][AREG_W-1:0] rd_idx_2;
    logic [DISPATCH_W-1:0]             wr_en;
    logic [DISPATCH_W-1:0][AREG_W-1:0] wr_idx;
    tag_t [DISPATCH_W-1:0]             wr_tag;
    tag_t [DISPATCH_W-1:0]             rd_out_1;
    tag_t [DISPATCH_W-1:0]             rd_out_2;
    tag_t [DISPATCH_W-1:0]             told_out;
    logic [CDB_W-1:0]                  cdb_en;
    tag_t [CDB_W-1:0]                  cdb_tag;
    logic                              ckpt_req;
    logic [WAY_W-1:0]                  ckpt_way;
    logic [CKPT_W-1:0]                 ckpt_id;
    logic                              ckpt_full;
    logic                              br_resolve;
    logic                              br_mispredict;
    logic [CKPT_W-1:0]                 br_id;
    logic                              interrupt;
    logic [RETIRE_W-1:0]               retire_en;
    logic [RETIRE_W-1:0][AREG_W-1:0]   retire_idx;
    tag_t [RETIRE_W-1:0]               retire_tag;

    modport master (
        output rd_idx_1, rd_idx_2, wr_en, wr_idx, wr_tag, cdb_en, cdb_tag, ckpt_req, ckpt_way,
               br_resolve, br_mispredict, br_id, interrupt, retire_en, retire_idx, retire_tag,
        input  rd_out_1, rd_out_2, told_out, ckpt_id, ckpt_full
    );
    modport slave (
        input  rd_idx_1, rd_idx_2, wr_en, wr_idx, wr_tag, cdb_en, cdb_tag, ckpt_req, ckpt_way,
               br_resolve, br_mispredict, br_id, interrupt, retire_en, retire_idx, retire_tag,
        output rd_out_1, rd_out_2, told_out, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/map_table_ckpt_stack.sv
// Circular stack of map snapshots with CDB wakeup and a single-cycle restore port.
module map_ckpt_stack
    import map_table_ckpt_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc,
    input  map_t                snap,
    input  br_pkt_t             br,
    input  logic                flush,
    input  logic [CDB_W-1:0]    cdb_en,
    input  tag_t [CDB_W-1:0]    cdb_tag,
    output logic [CKPT_W-1:0]   tail,
    output logic                full,
    output map_t                restore
);
    map_t [NUM_CKPT-1:0] slot_q;
    logic [CKPT_W-1:0]   head_q, tail_q;
    logic [CKPT_W:0]     count_q;
    logic                pop;

    assign tail = tail_q;
    assign full = (count_q == (CKPT_W+1)'(NUM_CKPT));
    assign pop  = br.resolve && (count_q != '0);

    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGS; i++)
            restore[i] = wake(slot_q[br.id][i], cdb_en, cdb_tag);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (br.mispredict) begin
            // Everything younger than the mispredicted branch is dropped
            tail_q  <= br.id + 1'b1;
            count_q <= {1'b0, CKPT_W'(br.id - head_q)} + 1'b1;
        end else begin
            head_q  <= head_q + CKPT_W'(pop);
            tail_q  <= tail_q + CKPT_W'(alloc);
            count_q <= count_q + (CKPT_W+1)'(alloc) - (CKPT_W+1)'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_CKPT; s++)
                for (int i = 0; i < NUM_ARCH_REGS; i++)
                    slot_q[s][i] <= reset_tag(i);
        end else begin
            for (int s = 0; s < NUM_CKPT; s++) begin
                if (alloc && tail_q == CKPT_W'(s))
                    slot_q[s] <= snap;
                else
                    for (int i = 0; i < NUM_ARCH_REGS; i++)
                        slot_q[s][i] <= wake(slot_q[s][i], cdb_en, cdb_tag);
            end
        end
    end
endmodule

// File: rtl/map_table_ckpt.sv
// Rename map table: combinational lookups with intra-group forwarding, CDB wakeup,
// retirement into the architectural map, and checkpoint/interrupt recovery.
module map_table_ckpt
    import map_table_ckpt_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    map_table_ckpt_if.slave  bus
);
    map_t                          map_q, map_n, arch_q, arch_n, snap_map, restore_map;
    wr_pkt_t [DISPATCH_W-1:0]      wr;
    retire_pkt_t [RETIRE_W-1:0]    rt;
    br_pkt_t                       br;
    logic                          full, alloc;
    logic [CKPT_W-1:0]             tail;

    always_comb begin
        for (int j = 0; j < DISPATCH_W; j++)
            wr[j] = '{en: bus.wr_en[j], idx: bus.wr_idx[j], tag: bus.wr_tag[j]};
        for (int p = 0; p < RETIRE_W; p++)
            rt[p] = '{en: bus.retire_en[p], idx: bus.retire_idx[p], tag: bus.retire_tag[p]};
    end

    assign br = '{resolve: bus.br_resolve, mispredict: bus.br_mispredict, id: bus.br_id};
    assign alloc = bus.ckpt_req && !full && !bus.interrupt && !bus.br_mispredict;
    assign bus.ckpt_id   = tail;
    assign bus.ckpt_full = full;

    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            bus.rd_out_1[k] = wake(fwd(k, bus.rd_idx_1[k], map_q, wr), bus.cdb_en, bus.cdb_tag);
            bus.rd_out_2[k] = wake(fwd(k, bus.rd_idx_2[k], map_q, wr), bus.cdb_en, bus.cdb_tag);
            bus.told_out[k] = fwd(k, bus.wr_idx[k], map_q, wr);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGS; i++)
            map_n[i] = wake(map_q[i], bus.cdb_en, bus.cdb_tag);
        snap_map = map_n;
        // Dispatch tags overwrite after wakeup so they keep their own ready bit
        for (int j = 0; j < DISPATCH_W; j++) begin
            if (wr[j].en && wr[j].idx != '0) begin
                map_n[wr[j].idx] = wr[j].tag;
                if (j <= int'(bus.ckpt_way)) snap_map[wr[j].idx] = wr[j].tag;
            end
        end
        arch_n = arch_q;
        for (int p = 0; p < RETIRE_W; p++)
            if (rt[p].en && rt[p].idx != '0)
                arch_n[rt[p].idx] = '{phys_reg: rt[p].tag.phys_reg, valid: 1'b1, ready: 1'b1};
        if (bus.interrupt)
            map_n = arch_n;
        else if (bus.br_mispredict)
            map_n = restore_map;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i]  <= reset_tag(i);
                arch_q[i] <= reset_tag(i);
            end
        end else begin
            map_q  <= map_n;
            arch_q <= arch_n;
        end
    end

    map_ckpt_stack u_stack (
        .clock   (clock),
        .reset   (reset),
        .alloc   (alloc),
        .snap    (snap_map),
        .br      (br),
        .flush   (bus.interrupt),
        .cdb_en  (bus.cdb_en),
        .cdb_tag (bus.cdb_tag),
        .tail    (tail),
        .full    (full),
        .restore (restore_map)
    );
endmodule

// File: tb/tb_map_table_ckpt.sv
// Directed stimulus with a cycle-tagged scoreboard checked by a negedge monitor.
module tb_map_table_ckpt;
    import map_table_ckpt_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    map_table_ckpt_if bus();
    map_table_ckpt dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        int         cyc;
        string      name;
        int         sel;   // 0 rd_out_1, 1 rd_out_2, 2 told_out, 3 ckpt_id, 4 ckpt_full
        int         way;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic tag_t T(input int p, input bit v, input bit r);
        tag_t t;
        t.phys_reg = PREG_W'(p);
        t.valid    = v;
        t.ready    = r;
        return t;
    endfunction

    task automatic expect_val(input string name, input int sel, input int way, input logic [7:0] v);
        exp_t e;
        e.cyc = cyc; e.name = name; e.sel = sel; e.way = way; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        bus.rd_idx_1 = '0; bus.rd_idx_2 = '0;
        bus.wr_en = '0; bus.wr_idx = '0; bus.wr_tag = '0;
        bus.cdb_en = '0; bus.cdb_tag = '0;
        bus.ckpt_req = 1'b0; bus.ckpt_way = '0;
        bus.br_resolve = 1'b0; bus.br_mispredict = 1'b0; bus.br_id = '0;
        bus.interrupt = 1'b0;
        bus.retire_en = '0; bus.retire_idx = '0; bus.retire_tag = '0;
    endtask

    always @(negedge clock) begin : monitor
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            case (e.sel)
                0:       act = bus.rd_out_1[e.way];
                1:       act = bus.rd_out_2[e.way];
                2:       act = bus.told_out[e.way];
                3:       act = 8'(bus.ckpt_id);
                default: act = 8'(bus.ckpt_full);
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    initial begin
        step();
        step();
        reset = 1'b1;

        step();  // reset state
        bus.rd_idx_1[0] = 5;
        expect_val("reset_r5", 0, 0, T(5, 1, 1));
        expect_val("reset_r0", 1, 0, T(0, 1, 1));
        expect_val("reset_full", 4, 0, 8'd0);
        expect_val("reset_id", 3, 0, 8'd0);

        step();  // same-cycle forwarding r3->P40
        bus.wr_en[0] = 1'b1; bus.wr_idx[0] = 3; bus.wr_tag[0] = T(40, 1, 0);
        bus.rd_idx_1[1] = 3; bus.rd_idx_2[0] = 3;
        expect_val("fwd_w1_r3", 0, 1, T(40, 1, 0));
        expect_val("nofwd_w0_r3", 1, 0, T(3, 1, 1));
        expect_val("told_w0", 2, 0, T(3, 1, 1));

        step();  // r7->P50 not ready
        bus.wr_en[0] = 1'b1; bus.wr_idx[0] = 7; bus.wr_tag[0] = T(50, 1, 0);
        bus.rd_idx_1[0] = 3;
        expect_val("map_r3", 0, 0, T(40, 1, 0));

        step();  // CDB P50 wakes lookup combinationally
        bus.cdb_en[0] = 1'b1; bus.cdb_tag[0] = T(50, 1, 1);
        bus.rd_idx_1[0] = 7; bus.rd_idx_2[0] = 3;
        expect_val("cdb_bypass_r7", 0, 0, T(50, 1, 1));
        expect_val("cdb_nohit_r3", 1, 0, T(40, 1, 0));

        step();
        bus.rd_idx_1[0] = 7;
        expect_val("cdb_stored_r7", 0, 0, T(50, 1, 1));

        step();  // checkpoint after way0 only; WAW r4
        bus.ckpt_req = 1'b1; bus.ckpt_way = 0;
        bus.wr_en = 2'b11;
        bus.wr_idx[0] = 4; bus.wr_tag[0] = T(41, 1, 0);
        bus.wr_idx[1] = 4; bus.wr_tag[1] = T(42, 1, 0);
        expect_val("ckpt_id0", 3, 0, 8'd0);
        expect_val("ckpt_nfull", 4, 0, 8'd0);
        expect_val("told_w1_fwd", 2, 1, T(41, 1, 0));
        expect_val("told_w0_r4", 2, 0, T(4, 1, 1));

        step();
        bus.rd_idx_1[0] = 4;
        expect_val("waw_r4", 0, 0, T(42, 1, 0));
        expect_val("tail_after_ckpt", 3, 0, 8'd1);

        step();  // mispredict id 0 with CDB P41; write and ckpt_req discarded
        bus.br_mispredict = 1'b1; bus.br_id = 0;
        bus.cdb_en[1] = 1'b1; bus.cdb_tag[1] = T(41, 1, 1);
        bus.wr_en[0] = 1'b1; bus.wr_idx[0] = 5; bus.wr_tag[0] = T(60, 1, 0);
        bus.ckpt_req = 1'b1;

        step();
        bus.rd_idx_1[0] = 4; bus.rd_idx_2[0] = 5; bus.rd_idx_1[1] = 7;
        expect_val("restore_r4", 0, 0, T(41, 1, 1));
        expect_val("discard_r5", 1, 0, T(5, 1, 1));
        expect_val("restore_r7", 0, 1, T(50, 1, 1));
        expect_val("tail_after_mp", 3, 0, 8'd1);

        step();  // drain the one live checkpoint
        bus.br_resolve = 1'b1; bus.br_id = 0;

        for (int n = 0; n < NUM_CKPT; n++) begin
            step();
            bus.ckpt_req = 1'b1;
            expect_val("fill_id", 3, 0, 8'((1 + n) % NUM_CKPT));
            expect_val("fill_nfull", 4, 0, 8'd0);
        end

        step();  // full: request ignored
        bus.ckpt_req = 1'b1;
        expect_val("full_set", 4, 0, 8'd1);
        expect_val("full_id", 3, 0, 8'd1);

        step();
        bus.br_resolve = 1'b1; bus.br_id = 1;
        expect_val("full_hold", 4, 0, 8'd1);
        expect_val("full_ignored_id", 3, 0, 8'd1);

        step();  // count now 3: one more allocation refills
        bus.ckpt_req = 1'b1;
        expect_val("resolve_nfull", 4, 0, 8'd0);
        expect_val("resolve_id", 3, 0, 8'd1);

        step();
        expect_val("refull", 4, 0, 8'd1);
        expect_val("refull_id", 3, 0, 8'd2);

        step();  // retire r2->P45
        bus.retire_en[0] = 1'b1; bus.retire_idx[0] = 2; bus.retire_tag[0] = T(45, 1, 0);

        step();  // rename r2->P46
        bus.wr_en[0] = 1'b1; bus.wr_idx[0] = 2; bus.wr_tag[0] = T(46, 1, 0);

        step();  // interrupt with a same-cycle retire r6->P33
        bus.rd_idx_1[0] = 2;
        bus.interrupt = 1'b1;
        bus.retire_en[1] = 1'b1; bus.retire_idx[1] = 6; bus.retire_tag[1] = T(33, 1, 0);
        expect_val("spec_r2", 0, 0, T(46, 1, 0));

        step();
        bus.rd_idx_1[0] = 2; bus.rd_idx_2[0] = 6; bus.rd_idx_1[1] = 4; bus.rd_idx_2[1] = 3;
        expect_val("intr_r2", 0, 0, T(45, 1, 1));
        expect_val("intr_r6", 1, 0, T(33, 1, 1));
        expect_val("intr_r4", 0, 1, T(4, 1, 1));
        expect_val("intr_r3", 1, 1, T(3, 1, 1));
        expect_val("intr_nfull", 4, 0, 8'd0);
        expect_val("intr_id", 3, 0, 8'd0);

        step();
        step();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
